// File: rtl/io_input_conditioner.sv
// Input conditioning for the pico_mips core: synchronises switches and button,
// debounces the button and freezes the operand while the handshake is high.

module io_sync_bit (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module io_input_conditioner #(
  parameter int N              = 8,
  parameter int DebounceCycles = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_raw,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] in_bus,
  output logic         io_handshake,
  output logic         press_pulse,
  output logic         release_pulse
);
  localparam int CW = $clog2(DebounceCycles) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DebounceCycles - 1);

  typedef enum logic [1:0] {LOW, ARM_HIGH, HIGH, ARM_LOW} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          press_nxt, release_nxt, hs_nxt;
  logic          b2;
  logic [N-1:0]  s2;

  io_sync_bit u_btn_sync (.clk(clk), .reset(reset), .d(btn_raw), .q(b2));

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_sw
      io_sync_bit u_sw_sync (.clk(clk), .reset(reset), .d(sw_raw[i]), .q(s2[i]));
    end
  endgenerate

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      LOW: if (b2) begin
        state_nxt = ARM_HIGH;
        cnt_nxt   = CW'(1);
      end
      ARM_HIGH: begin
        if (!b2) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HIGH: if (!b2) begin
        state_nxt = ARM_LOW;
        cnt_nxt   = CW'(1);
      end
      ARM_LOW: begin
        if (b2) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = LOW;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
      end
    endcase
    hs_nxt = (state_nxt == HIGH) || (state_nxt == ARM_LOW);
  end

  // in_bus follows s2 while the registered handshake is low, which also
  // captures s2 on the rising edge itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LOW;
      cnt           <= '0;
      io_handshake  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      in_bus        <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      io_handshake  <= hs_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      if (!io_handshake) in_bus <= s2;
    end
  end
endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares
// every cycle; pulse counts are checked per phase.

module tb_io_input_conditioner;
  localparam int N = 8;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         btn_raw = 1'b0;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] in_bus;
  logic         io_handshake, press_pulse, release_pulse;

  always #5 clk = ~clk;

  io_input_conditioner #(.N(N), .DebounceCycles(D)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .in_bus(in_bus), .io_handshake(io_handshake),
    .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  typedef struct packed {
    logic [N-1:0] bus;
    logic         hs;
    logic         pp;
    logic         rp;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp, mon_act;
  int total = 0, bad = 0;
  int dut_press = 0, dut_rel = 0, mdl_press = 0, mdl_rel = 0;
  int p0 = 0, r0 = 0;

  // Reference: raw inputs seen through a 2-deep delay line; the level flips
  // once D consecutive delayed samples disagree with it.
  logic         bh [2];
  logic [N-1:0] sh [2];
  logic         lvl = 1'b0;
  int           run = 0;
  logic [N-1:0] m_bus = '0;
  logic         m_pp = 1'b0, m_rp = 1'b0;

  task automatic model_step(input logic r, input logic b, input logic [N-1:0] s);
    if (r) begin
      bh[0] = 1'b0; bh[1] = 1'b0; sh[0] = '0; sh[1] = '0;
      lvl = 1'b0; run = 0; m_bus = '0; m_pp = 1'b0; m_rp = 1'b0;
    end else begin
      if (!lvl) m_bus = sh[1];
      m_pp = 1'b0;
      m_rp = 1'b0;
      if (bh[1] != lvl) begin
        run++;
        if (run == D) begin
          lvl = ~lvl;
          run = 0;
          if (lvl) begin m_pp = 1'b1; mdl_press++; end
          else     begin m_rp = 1'b1; mdl_rel++;   end
        end
      end else begin
        run = 0;
      end
      bh[1] = bh[0]; bh[0] = b;
      sh[1] = sh[0]; sh[0] = s;
    end
  endtask

  task automatic cyc(input logic r, input logic b, input logic [N-1:0] s);
    obs_t e;
    @(negedge clk);
    reset = r; btn_raw = b; sw_raw = s;
    model_step(r, b, s);
    e.bus = m_bus; e.hs = lvl; e.pp = m_pp; e.rp = m_rp;
    exp_q.push_back(e);
  endtask

  // One more held cycle, then let the monitor consume it.
  task automatic sync_mon();
    cyc(reset, btn_raw, sw_raw);
    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sync_queue pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic check_delta(input string name, input int ep, input int er);
    sync_mon();
    total++;
    if ((dut_press - p0) != ep || (dut_rel - r0) != er) begin
      bad++;
      $display("FAIL %s press=%0d release=%0d required press=%0d release=%0d",
               name, dut_press - p0, dut_rel - r0, ep, er);
    end
    p0 = dut_press;
    r0 = dut_rel;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (press_pulse === 1'b1) dut_press++;
      if (release_pulse === 1'b1) dut_rel++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {in_bus, io_handshake, press_pulse, release_pulse};
        total++;
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL cycle t=%0t got bus=%h hs=%b pp=%b rp=%b required bus=%h hs=%b pp=%b rp=%b",
                   $time, mon_act.bus, mon_act.hs, mon_act.pp, mon_act.rp,
                   mon_exp.bus, mon_exp.hs, mon_exp.pp, mon_exp.rp);
        end
      end
    end
  end

  initial begin
    bh[0] = 1'b0; bh[1] = 1'b0; sh[0] = '0; sh[1] = '0;
    repeat (3) cyc(1'b1, 1'b0, '0);
    check_delta("reset", 0, 0);

    // clean press with operand CE, switch change while held, release
    repeat (3) cyc(1'b0, 1'b0, 8'hCE);
    repeat (8) cyc(1'b0, 1'b1, 8'hCE);
    repeat (5) cyc(1'b0, 1'b1, 8'h8B);
    repeat (8) cyc(1'b0, 1'b0, 8'h8B);
    check_delta("clean_press_release", 1, 1);

    // bounce then hold
    cyc(1'b0, 1'b1, 8'h8B); cyc(1'b0, 1'b0, 8'h8B);
    cyc(1'b0, 1'b1, 8'h8B); cyc(1'b0, 1'b0, 8'h8B);
    repeat (8) cyc(1'b0, 1'b1, 8'h8B);
    check_delta("bounce_press", 1, 0);
    repeat (8) cyc(1'b0, 1'b0, 8'h8B);
    check_delta("bounce_release", 0, 1);

    // short glitch
    repeat (2) cyc(1'b0, 1'b1, 8'h31);
    repeat (8) cyc(1'b0, 1'b0, 8'h31);
    check_delta("glitch", 0, 0);

    // reset while HIGH, button still held afterwards
    repeat (3) cyc(1'b0, 1'b0, 8'h22);
    repeat (8) cyc(1'b0, 1'b1, 8'h22);
    check_delta("pre_reset_press", 1, 0);
    cyc(1'b1, 1'b1, 8'h22);
    repeat (8) cyc(1'b0, 1'b1, 8'h22);
    check_delta("reset_in_high", 1, 0);
    repeat (8) cyc(1'b0, 1'b0, 8'h22);
    check_delta("post_reset_release", 0, 1);

    // two-operand session with switches scrambled while frozen
    for (int op = 0; op < 2; op++) begin
      logic [N-1:0] v;
      v = (op == 0) ? 8'h22 : 8'h55;
      repeat (4) cyc(1'b0, 1'b0, v);
      repeat (10) cyc(1'b0, 1'b1, v);
      repeat (1990) cyc(1'b0, 1'b1, N'($urandom));
      repeat (20) cyc(1'b0, 1'b0, v);
    end
    check_delta("session", 2, 2);

    // random bursts with occasional reset
    for (int k = 0; k < 700; k++) begin
      logic b, r;
      int len;
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 99) < 2);
      len = $urandom_range(1, 6);
      cyc(r, b, N'($urandom));
      for (int j = 1; j < len; j++) cyc(1'b0, b, N'($urandom));
    end
    sync_mon();
    total++;
    if (dut_press != mdl_press || dut_rel != mdl_rel) begin
      bad++;
      $display("FAIL pulse_totals press=%0d release=%0d required press=%0d release=%0d",
               dut_press, dut_rel, mdl_press, mdl_rel);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
